e_mdu: RTL and testbench

E_MDU -- requirements
Module: E_MDU

---
 rtl/e_mdu_pkg.sv | 30 +++
 rtl/e_mdu_calc.sv | 62 ++++++
 rtl/e_mdu.sv | 118 +++++++++++
 tb/tb_e_mdu.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/e_mdu_pkg.sv
// ---------------------------------------------------------------------------
// e_mdu_pkg -- shared types and encodings for the E-stage multiply/divide unit.
//   mdu_op_e    : MDUOp encodings, kept beside the ALU op codes for decode.
//   mdu_state_e : sequencer states (IDLE / RUN).
//   max2        : helper used to size the cycle counter.
// ---------------------------------------------------------------------------
package e_mdu_pkg;

   typedef enum logic [3:0] {
      MDU_NONE  = 4'd0,
      MDU_MULT  = 4'd1,
      MDU_MULTU = 4'd2,
      MDU_DIV   = 4'd3,
      MDU_DIVU  = 4'd4,
      MDU_MTHI  = 4'd5,
      MDU_MTLO  = 4'd6,
      MDU_MFHI  = 4'd7,
      MDU_MFLO  = 4'd8
   } mdu_op_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } mdu_state_e;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// ---------------------------------------------------------------------------
// e_mdu_calc -- combinational multiply/divide datapath.
//   op   : latched operation (MULT/MULTU/DIV/DIVU; anything else -> wr=0)
//   a, b : latched operands
//   hi   : product upper half / remainder
//   lo   : product lower half / quotient
//   wr   : result should be committed (0 for divide-by-zero or non-arith op)
// ---------------------------------------------------------------------------
module e_mdu_calc
   import e_mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  mdu_op_e          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             wr
);

   logic [2*WIDTH-1:0] sprod, uprod;
   logic               sgn;
   logic [WIDTH-1:0]   dvd, dvs, uq, ur;

   // Sign-extending to 2*WIDTH before an unsigned multiply yields the
   // two's-complement signed product modulo 2^(2*WIDTH).
   assign sprod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
   assign uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

   // Signed division runs on magnitudes; signs are restored afterwards.
   // The most-negative value's magnitude fits as unsigned, so MIN / -1
   // naturally wraps back to MIN with remainder 0.
   assign sgn = (op == MDU_DIV);
   assign dvd = (sgn && a[WIDTH-1]) ? -a : a;
   assign dvs = (b == '0) ? WIDTH'(1) : ((sgn && b[WIDTH-1]) ? -b : b);
   assign uq  = dvd / dvs;
   assign ur  = dvd % dvs;

   always_comb begin
      hi = '0;
      lo = '0;
      wr = 1'b0;
      case (op)
         MDU_MULT: begin
            {hi, lo} = sprod;
            wr       = 1'b1;
         end
         MDU_MULTU: begin
            {hi, lo} = uprod;
            wr       = 1'b1;
         end
         MDU_DIV, MDU_DIVU: begin
            lo = (sgn && (a[WIDTH-1] ^ b[WIDTH-1])) ? -uq : uq;
            hi = (sgn && a[WIDTH-1]) ? -ur : ur;
            wr = (b != '0);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/e_mdu.sv
// ---------------------------------------------------------------------------
// e_mdu -- E-stage multiply/divide unit with HI/LO registers.
//   clk, reset : clock (rising edge), synchronous active-high reset
//   A, B       : forwarded rs / rt operands
//   MDUOp      : operation select (e_mdu_pkg::mdu_op_e)
//   Start      : E-stage instruction is mult/multu/div/divu
//   Req        : exception/interrupt this cycle, suppresses E-stage effects
//   Busy       : multi-cycle operation in progress
//   HI_out     : architectural HI
//   LO_out     : architectural LO
//   MDU_out    : MFHI -> HI, MFLO -> LO, else 0 (combinational)
// ---------------------------------------------------------------------------
module e_mdu
   import e_mdu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       MDUOp,
   input  logic             Start,
   input  logic             Req,
   output logic             Busy,
   output logic [WIDTH-1:0] HI_out,
   output logic [WIDTH-1:0] LO_out,
   output logic [WIDTH-1:0] MDU_out
);

   localparam int CNT_W = $clog2(max2(MULT_CYCLES, DIV_CYCLES) + 1);

   mdu_state_e       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0] a_q, b_q, hi, lo, calc_hi, calc_lo;
   mdu_op_e          op, op_q;
   logic             accept, commit, calc_wr;

   assign op = mdu_op_e'(MDUOp);

   e_mdu_calc #(.WIDTH(WIDTH)) u_calc (
      .op (op_q),
      .a  (a_q),
      .b  (b_q),
      .hi (calc_hi),
      .lo (calc_lo),
      .wr (calc_wr)
   );

   // Start is only looked at in IDLE, so a Start that arrives while
   // busy is dropped; the hazard unit re-presents it after the stall.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      commit    = 1'b0;
      case (state)
         S_IDLE: begin
            if (Start && !Req) begin
               accept    = 1'b1;
               state_nxt = S_RUN;
               cnt_nxt   = (op == MDU_DIV || op == MDU_DIVU) ? CNT_W'(DIV_CYCLES)
                                                             : CNT_W'(MULT_CYCLES);
            end
         end
         S_RUN: begin
            if (cnt == CNT_W'(1)) begin
               commit    = 1'b1;
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= MDU_NONE;
         hi    <= '0;
         lo    <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= op;
         end
         // MT* cannot reach E while busy (stalled), so commit taking
         // priority never hides a real move.
         if (commit) begin
            if (calc_wr) begin
               hi <= calc_hi;
               lo <= calc_lo;
            end
         end else if (!Req) begin
            if (op == MDU_MTHI) hi <= A;
            if (op == MDU_MTLO) lo <= A;
         end
      end
   end

   assign Busy    = (state == S_RUN);
   assign HI_out  = hi;
   assign LO_out  = lo;
   assign MDU_out = (op == MDU_MFHI) ? hi :
                    (op == MDU_MFLO) ? lo : '0;

endmodule

// File: tb/tb_e_mdu.sv
// ---------------------------------------------------------------------------
// tb_e_mdu -- directed self-checking bench for e_mdu (default 32-bit build
// plus a 16-bit single-cycle build).
// ---------------------------------------------------------------------------
module tb_e_mdu;
   import e_mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] A, B, hi, lo, mdo;
   logic [3:0]  op;
   logic        start, req, busy;

   logic [15:0] a2, b2, hi2, lo2, mdo2;
   logic [3:0]  op2;
   logic        start2, req2, busy2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   e_mdu dut (
      .clk(clk), .reset(reset), .A(A), .B(B), .MDUOp(op), .Start(start),
      .Req(req), .Busy(busy), .HI_out(hi), .LO_out(lo), .MDU_out(mdo)
   );

   e_mdu #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut16 (
      .clk(clk), .reset(reset), .A(a2), .B(b2), .MDUOp(op2), .Start(start2),
      .Req(req2), .Busy(busy2), .HI_out(hi2), .LO_out(lo2), .MDU_out(mdo2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one multi-cycle op, count busy cycles, check result.
   task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int ncyc,
                         input logic [31:0] ehi, input logic [31:0] elo);
      int n;
      A = a; B = b; op = o; start = 1'b1;
      chk({tag, "_bsy_start"}, {31'd0, busy}, 32'd0);
      step();
      start = 1'b0; op = MDU_NONE;
      n = 0;
      while (busy && n < 100) begin
         n++;
         step();
      end
      chk({tag, "_cycles"}, n, ncyc);
      chk({tag, "_hi"}, hi, ehi);
      chk({tag, "_lo"}, lo, elo);
   endtask

   initial begin
      int n;
      reset = 1'b1; A = '0; B = '0; op = MDU_NONE; start = 1'b0; req = 1'b0;
      a2 = '0; b2 = '0; op2 = MDU_NONE; start2 = 1'b0; req2 = 1'b0;
      step(); step();
      reset = 1'b0;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_mdo", mdo, 32'd0);

      run_op("mult", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      op = MDU_MFHI; #1 chk("mfhi", mdo, 32'hFFFF_FFFF);
      op = MDU_MFLO; #1 chk("mflo", mdo, 32'hFFFF_FFFA);
      op = MDU_NONE; #1 chk("mf_none", mdo, 32'd0);

      run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("div", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu0", MDU_DIVU, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divmin", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
      run_op("div_negb", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 10, 32'h1, 32'hFFFF_FFFD);
      run_op("divu", MDU_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);

      // Move-to with and without Req
      A = 32'hAAAA; op = MDU_MTHI; step();
      op = MDU_NONE;
      chk("mthi", hi, 32'hAAAA);
      chk("mthi_busy", {31'd0, busy}, 32'd0);
      A = 32'h1234; op = MDU_MTLO; req = 1'b1; step();
      op = MDU_NONE; req = 1'b0;
      chk("mtlo_req", lo, 32'd14);

      // Start suppressed by Req
      A = 32'd5; B = 32'd5; op = MDU_MULT; start = 1'b1; req = 1'b1; step();
      start = 1'b0; req = 1'b0; op = MDU_NONE;
      chk("req_busy", {31'd0, busy}, 32'd0);
      step(); step(); step(); step(); step(); step();
      chk("req_hi", hi, 32'hAAAA);
      chk("req_lo", lo, 32'd14);

      // Reset mid-run aborts without commit
      A = 32'd5; B = 32'd6; op = MDU_MULTU; start = 1'b1; step();
      start = 1'b0; op = MDU_NONE;
      step(); step();
      chk("abort_busy_pre", {31'd0, busy}, 32'd1);
      reset = 1'b1; step(); reset = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      for (int i = 0; i < 8; i++) step();
      chk("abort_late_lo", lo, 32'd0);
      chk("abort_late_busy", {31'd0, busy}, 32'd0);

      // Start while busy is ignored
      A = 32'd3; B = 32'd4; op = MDU_MULT; start = 1'b1; step();
      start = 1'b0; op = MDU_NONE;
      n = 0;
      while (busy && n < 100) begin
         if (n == 1) begin
            A = 32'd100; B = 32'd100; op = MDU_MULT; start = 1'b1;
         end else begin
            start = 1'b0; op = MDU_NONE;
         end
         n++;
         step();
      end
      start = 1'b0; op = MDU_NONE;
      chk("rest_cycles", n, 5);
      chk("rest_lo", lo, 32'd12);
      chk("rest_hi", hi, 32'd0);
      step();
      chk("rest_idle", {31'd0, busy}, 32'd0);

      // 16-bit, single-cycle build
      a2 = 16'hFFFE; b2 = 16'd3; op2 = MDU_MULT; start2 = 1'b1; step();
      start2 = 1'b0; op2 = MDU_NONE;
      chk("w16_mult_busy1", {31'd0, busy2}, 32'd1);
      step();
      chk("w16_mult_busy0", {31'd0, busy2}, 32'd0);
      chk("w16_mult_hi", {16'd0, hi2}, 32'hFFFF);
      chk("w16_mult_lo", {16'd0, lo2}, 32'hFFFA);
      a2 = 16'hFFF9; b2 = 16'd2; op2 = MDU_DIV; start2 = 1'b1; step();
      start2 = 1'b0; op2 = MDU_NONE;
      chk("w16_div_busy1", {31'd0, busy2}, 32'd1);
      step();
      chk("w16_div_busy0", {31'd0, busy2}, 32'd0);
      chk("w16_div_hi", {16'd0, hi2}, 32'hFFFF);
      chk("w16_div_lo", {16'd0, lo2}, 32'hFFFD);
      a2 = 16'hFFFF; b2 = 16'hFFFF; op2 = MDU_MULTU; start2 = 1'b1; step();
      start2 = 1'b0; op2 = MDU_NONE;
      step();
      chk("w16_multu_hi", {16'd0, hi2}, 32'hFFFE);
      chk("w16_multu_lo", {16'd0, lo2}, 32'h0001);
      op2 = MDU_MFLO; #1 chk("w16_mflo", {16'd0, mdo2}, 32'h0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
